// File: rtl/square_pkg.sv
// Shared definitions for the square-wave audio path: decoder FSM states and
// default field widths common to the generator and decoder.
package square_pkg;

    localparam int unsigned DEF_CNT_W  = 21;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned CNT_MAX    = (1 << DEF_CNT_W) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/square_level_det.sv
// Slices the sample stream into a high/low level and flags the cycle in which
// the level rises; the previous level keeps tracking even while the decoder is idle.
module square_level_det
    import square_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned THRESH = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample,
    output logic              level_c,
    output logic              level_q,
    output logic              rise_c
);

    assign level_c = (sample > DATA_W'(THRESH));
    assign rise_c  = level_c & ~level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_c;
        end
    end

endmodule

// File: rtl/square_decode.sv
// Square-wave decoder: measures period, high length and volume of each completed
// period of the generator's sample stream, with counter-saturation timeout.
module square_decode
    import square_pkg::*;
#(
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned THRESH = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample,
    output logic              meas_valid,
    output logic [CNT_W-1:0]  meas_period,
    output logic [CNT_W-1:0]  meas_active,
    output logic [DATA_W-1:0] meas_volume,
    output logic              meas_err,
    output logic              timeout
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = '1;

    state_t             state;
    state_t             state_nxt;
    logic               level_c;
    logic               level_q;
    logic               rise_c;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   high_cnt;
    logic [DATA_W-1:0]  vol_q;
    logic               err_q;
    logic               load_c;
    logic               step_c;
    logic               publish_c;
    logic               sat_c;

    square_level_det #(
        .DATA_W (DATA_W),
        .THRESH (THRESH)
    ) u_level_det (
        .clk     (clk),
        .rst_n   (rst_n),
        .sample  (sample),
        .level_c (level_c),
        .level_q (level_q),
        .rise_c  (rise_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Disable overrides everything; saturation without a rise falls back to ARM.
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ARM;
                ARM:     if (rise_c) state_nxt = RUN;
                RUN:     if (!rise_c && (cnt == CNT_LIMIT)) state_nxt = ARM;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A rise at saturation still publishes: the rise takes priority over timeout.
    always_comb begin
        load_c    = 1'b0;
        step_c    = 1'b0;
        publish_c = 1'b0;
        sat_c     = 1'b0;
        if (enable) begin
            case (state)
                ARM: load_c = rise_c;
                RUN: begin
                    if (rise_c) begin
                        load_c    = 1'b1;
                        publish_c = 1'b1;
                    end else if (cnt == CNT_LIMIT) begin
                        sat_c = 1'b1;
                    end else begin
                        step_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            high_cnt <= '0;
            vol_q    <= '0;
            err_q    <= 1'b0;
        end else if (load_c) begin
            cnt      <= CNT_W'(1);
            high_cnt <= CNT_W'(1);
            vol_q    <= sample;
            err_q    <= 1'b0;
        end else if (step_c) begin
            cnt      <= cnt + CNT_W'(1);
            high_cnt <= high_cnt + CNT_W'(level_c);
            err_q    <= err_q | (level_c & (sample != vol_q));
        end else begin
            cnt      <= '0;
            high_cnt <= '0;
            vol_q    <= '0;
            err_q    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_valid  <= 1'b0;
            meas_period <= '0;
            meas_active <= '0;
            meas_volume <= '0;
            meas_err    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            meas_valid <= publish_c;
            timeout    <= sat_c;
            if (publish_c) begin
                meas_period <= cnt;
                meas_active <= high_cnt;
                meas_volume <= vol_q;
                meas_err    <= err_q;
            end
        end
    end

endmodule

// File: tb/tb_square_decode.sv
// Directed bench for square_decode: default instance, a 4-bit counter instance for
// saturation, and a raised-threshold instance, all sharing one stimulus stream.
module tb_square_decode;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] sample;

    logic        a_valid, a_err, a_timeout;
    logic [20:0] a_period, a_active;
    logic [15:0] a_volume;
    logic        b_valid, b_err, b_timeout;
    logic [3:0]  b_period, b_active;
    logic [15:0] b_volume;
    logic        c_valid, c_err, c_timeout;
    logic [20:0] c_period, c_active;
    logic [15:0] c_volume;

    int checks;
    int errors;

    square_decode dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample(sample),
        .meas_valid(a_valid), .meas_period(a_period), .meas_active(a_active),
        .meas_volume(a_volume), .meas_err(a_err), .timeout(a_timeout)
    );

    square_decode #(.CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample(sample),
        .meas_valid(b_valid), .meas_period(b_period), .meas_active(b_active),
        .meas_volume(b_volume), .meas_err(b_err), .timeout(b_timeout)
    );

    square_decode #(.THRESH(32'h0100)) dut_c (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample(sample),
        .meas_valid(c_valid), .meas_period(c_period), .meas_active(c_active),
        .meas_volume(c_volume), .meas_err(c_err), .timeout(c_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v0;
        logic [15:0] v1;
        logic [15:0] v2;
        int          lo_len;
        int          exp_period;
        int          exp_active;
        logic [15:0] exp_vol;
        logic        exp_err;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic en, input logic [15:0] s);
        enable = en;
        sample = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stray;
        logic [15:0] s;

        vecs[0] = '{16'h1234, 16'h1234, 16'h1234, 5, 8, 3, 16'h1234, 1'b0};
        vecs[1] = '{16'h1234, 16'h1234, 16'h1234, 5, 8, 3, 16'h1234, 1'b0};
        vecs[2] = '{16'h1234, 16'h1234, 16'h1234, 5, 8, 3, 16'h1234, 1'b0};
        vecs[3] = '{16'h0100, 16'h0100, 16'h0100, 5, 8, 3, 16'h0100, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 5, 8, 3, 16'h7FFF, 1'b0};
        vecs[5] = '{16'h1234, 16'h1235, 16'h1234, 4, 7, 3, 16'h1234, 1'b1};
        vecs[6] = '{16'h1234, 16'h1234, 16'h1234, 5, 8, 3, 16'h1234, 1'b0};
        vecs[7] = '{16'h0100, 16'h0100, 16'h0100, 2, 5, 3, 16'h0100, 1'b0};
        vecs[8] = '{16'h2222, 16'h2222, 16'h2222, 3, 6, 3, 16'h2222, 1'b0};

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        enable = 1'b0;
        sample = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_valid",   32'(a_valid),   0);
        chk("rst_a_period",  32'(a_period),  0);
        chk("rst_a_volume",  32'(a_volume),  0);
        chk("rst_b_timeout", 32'(b_timeout), 0);
        chk("rst_c_active",  32'(c_active),  0);
        #3 rst_n = 1'b1;

        // Periodic stream with volume changes and a glitched high phase
        tick(1'b1, 16'h0000);
        stray = 0;
        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < 3 + vecs[i].lo_len; k++) begin
                s = (k == 0) ? vecs[i].v0 : (k == 1) ? vecs[i].v1 :
                    (k == 2) ? vecs[i].v2 : 16'h0000;
                tick(1'b1, s);
                if (k == 0) begin
                    chk($sformatf("tbl%0d_valid", i), 32'(a_valid), (i > 0) ? 1 : 0);
                    if (i > 0) begin
                        chk($sformatf("tbl%0d_period", i), 32'(a_period), vecs[i-1].exp_period);
                        chk($sformatf("tbl%0d_active", i), 32'(a_active), vecs[i-1].exp_active);
                        chk($sformatf("tbl%0d_volume", i), 32'(a_volume), 32'(vecs[i-1].exp_vol));
                        chk($sformatf("tbl%0d_err", i),    32'(a_err),    32'(vecs[i-1].exp_err));
                    end
                end else if (a_valid || a_timeout) begin
                    stray++;
                end
            end
        end
        chk("tbl_stray_pulses", 32'(stray), 0);

        // Enable dropped mid-high phase, then two rises needed for the next valid
        tick(1'b1, 16'h1234);
        chk("en_close_valid",  32'(a_valid),  1);
        chk("en_close_period", 32'(a_period), 6);
        chk("en_close_volume", 32'(a_volume), 32'h2222);
        stray = 0;
        tick(1'b1, 16'h1234); stray += int'(a_valid | a_timeout);
        tick(1'b0, 16'h1234); stray += int'(a_valid | a_timeout);
        tick(1'b0, 16'h1234); stray += int'(a_valid | a_timeout);
        tick(1'b1, 16'h0000); stray += int'(a_valid | a_timeout);
        chk("en_hold_period", 32'(a_period), 6);
        chk("en_hold_volume", 32'(a_volume), 32'h2222);
        for (int k = 0; k < 8; k++) begin
            tick(1'b1, (k < 3) ? 16'h1234 : 16'h0000);
            stray += int'(a_valid | a_timeout);
        end
        chk("en_no_pulse", 32'(stray), 0);
        tick(1'b1, 16'h4444);
        chk("en_first_valid",  32'(a_valid),  1);
        chk("en_first_period", 32'(a_period), 8);
        chk("en_first_active", 32'(a_active), 3);
        chk("en_first_volume", 32'(a_volume), 32'h1234);
        tick(1'b1, 16'h4444);
        repeat (4) tick(1'b1, 16'h0000);
        tick(1'b1, 16'h1234);
        chk("en_second_period", 32'(a_period), 6);
        chk("en_second_active", 32'(a_active), 2);
        chk("en_second_volume", 32'(a_volume), 32'h4444);

        // Saturation on the 4-bit instance
        tick(1'b0, 16'h0000);
        tick(1'b1, 16'h0000);
        tick(1'b1, 16'h1234);
        chk("sat_arm_valid", 32'(b_valid), 0);
        stray = 0;
        repeat (14) begin
            tick(1'b1, 16'h0000);
            stray += int'(b_valid | b_timeout);
        end
        chk("sat_early_pulse", 32'(stray), 0);
        tick(1'b1, 16'h0000);
        chk("sat_timeout", 32'(b_timeout), 1);
        chk("sat_tmo_valid", 32'(b_valid), 0);
        tick(1'b1, 16'h0000);
        chk("sat_timeout_clear", 32'(b_timeout), 0);
        tick(1'b1, 16'h1234);
        chk("sat_rearm_valid", 32'(b_valid), 0);
        stray = 0;
        repeat (14) begin
            tick(1'b1, 16'h0000);
            stray += int'(b_valid | b_timeout);
        end
        chk("sat_run_pulse", 32'(stray), 0);
        tick(1'b1, 16'h1234);
        chk("sat_edge_valid",   32'(b_valid),   1);
        chk("sat_edge_period",  32'(b_period),  15);
        chk("sat_edge_active",  32'(b_active),  1);
        chk("sat_edge_volume",  32'(b_volume),  32'h1234);
        chk("sat_edge_timeout", 32'(b_timeout), 0);

        // Asynchronous reset mid-period, then threshold comparison
        tick(1'b1, 16'h1234);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_a_period", 32'(a_period), 0);
        chk("arst_a_volume", 32'(a_volume), 0);
        chk("arst_b_period", 32'(b_period), 0);
        chk("arst_b_valid",  32'(b_valid),  0);
        #2 rst_n = 1'b1;
        tick(1'b1, 16'h0000);
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 8; k++) begin
                tick(1'b1, (k < 2) ? 16'h0200 : (k < 5) ? 16'h0080 : 16'h0000);
                if (k == 0) begin
                    chk($sformatf("thr%0d_a_valid", p), 32'(a_valid), (p > 0) ? 1 : 0);
                    chk($sformatf("thr%0d_c_valid", p), 32'(c_valid), (p > 0) ? 1 : 0);
                    if (p > 0) begin
                        chk($sformatf("thr%0d_a_active", p), 32'(a_active), 5);
                        chk($sformatf("thr%0d_c_active", p), 32'(c_active), 2);
                        chk($sformatf("thr%0d_c_period", p), 32'(c_period), 8);
                        chk($sformatf("thr%0d_c_volume", p), 32'(c_volume), 32'h0200);
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
